// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT frame sequencer: frame length default,
// write-side FSM encoding and the layout of the IFFT core config word.
package ifft_pkg;

  localparam int          FRAME_LEN_DEFAULT = 64;
  localparam logic [13:0] SCALE_SCH_DEFAULT = 14'h2AAA;

  // Config word layout: bit0 selects forward/inverse, bits 14:1 carry the
  // per-stage scaling schedule, bit15 is padding and always zero.
  localparam int   CFG_DIR_BIT   = 0;
  localparam int   CFG_SCALE_LSB = 1;
  localparam int   CFG_SCALE_MSB = 14;
  localparam int   CFG_PAD_BIT   = 15;
  localparam logic CFG_INVERSE   = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIG  = 2'd1,
    RECEIVE = 2'd2
  } wr_state_t;

  // Build the config word for an inverse transform with the given schedule.
  function automatic logic [15:0] make_cfg(input logic [13:0] sch);
    logic [15:0] word;
    word = '0;
    word[CFG_DIR_BIT] = CFG_INVERSE;
    word[CFG_SCALE_MSB:CFG_SCALE_LSB] = sch;
    word[CFG_PAD_BIT] = 1'b0;
    return word;
  endfunction

endpackage

// File: rtl/ifft_pingpong_ram.sv
// Two-bank sample store. One write port and one registered read port; the
// bank select is simply the top address bit, so both banks share one array.
module ifft_pingpong_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [2*DEPTH];

  // Write port: store one sample into the selected bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Read port: output register only loads on a read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/ifft_frame_sequencer.sv
// Ping-pong sequencer between an IFFT core and an audio DAC. The write side
// configures the core and captures one output frame per bank; the read side
// plays a full bank back one sample per sampleTick. The two sides only meet
// through the per-bank FULL flags, so capture and playback overlap freely.
module ifft_frame_sequencer
  import ifft_pkg::*;
#(
  parameter int          FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter logic [13:0] SCALE_SCH = SCALE_SCH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] cfgData,
  output logic        cfgValid,
  input  logic        cfgReady,
  input  logic [31:0] tData,
  input  logic        tValid,
  input  logic        tLast,
  output logic        tReady,
  input  logic        sampleTick,
  output logic [15:0] val,
  output logic        frameErr,
  output logic        underrun
);

  // FRAME_LEN must be a power of two between 8 and 1024.
  localparam int            AW       = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  wr_state_t     state;
  wr_state_t     state_next;
  logic [AW-1:0] w_idx;
  logic          w_bank;
  logic [AW-1:0] r_idx;
  logic          r_bank;
  logic [1:0]    bank_full;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;
  logic          beat;
  logic          wr_at_last;
  logic          frame_end;
  logic          len_err;
  logic          rd_go;
  logic          rd_at_last;
  logic          val_zero;
  logic [15:0]   rd_data;
  logic          unused_imag;

  // Only the real half of each IFFT output sample is played back.
  assign unused_imag = ^tData[31:16];

  assign cfgData = make_cfg(SCALE_SCH);

  assign beat       = tValid && (state == RECEIVE);
  assign wr_at_last = (w_idx == LAST_IDX);
  assign frame_end  = beat && (wr_at_last || tLast);
  assign len_err    = beat && (tLast != wr_at_last);
  assign rd_go      = sampleTick && bank_full[r_bank];
  assign rd_at_last = (r_idx == LAST_IDX);

  // Write FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write FSM next state and handshake outputs; a bank is only targeted once EMPTY.
  always_comb begin
    state_next = state;
    cfgValid   = 1'b0;
    tReady     = 1'b0;
    case (state)
      IDLE: begin
        if (!bank_full[w_bank]) begin
          state_next = CONFIG;
        end
      end
      CONFIG: begin
        cfgValid = 1'b1;
        if (cfgReady) begin
          state_next = RECEIVE;
        end
      end
      RECEIVE: begin
        tReady = 1'b1;
        if (frame_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write pointer: advance per beat, restart and switch banks at frame end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_idx  <= '0;
      w_bank <= 1'b0;
    end else if (frame_end) begin
      w_idx  <= '0;
      w_bank <= ~w_bank;
    end else if (beat) begin
      w_idx <= w_idx + AW'(1);
    end
  end

  // Bank flag set/clear requests from the write and read sides.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (frame_end) begin
      full_set[w_bank] = 1'b1;
    end
    if (rd_go && rd_at_last) begin
      full_clr[r_bank] = 1'b1;
    end
  end

  // Bank flags: a write-side set and a read-side clear on different banks both land.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | full_set) & ~full_clr;
    end
  end

  // Read pointer: one step per serviced tick, switch banks after the last sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx  <= '0;
      r_bank <= 1'b0;
    end else if (rd_go) begin
      if (rd_at_last) begin
        r_idx  <= '0;
        r_bank <= ~r_bank;
      end else begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  // Status pulses and the output mute flag that forces val to zero on underrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frameErr <= 1'b0;
      underrun <= 1'b0;
      val_zero <= 1'b1;
    end else begin
      frameErr <= len_err;
      underrun <= sampleTick && !bank_full[r_bank];
      if (rd_go) begin
        val_zero <= 1'b0;
      end else if (sampleTick) begin
        val_zero <= 1'b1;
      end
    end
  end

  assign val = val_zero ? 16'h0000 : rd_data;

  ifft_pingpong_ram #(
    .DEPTH(FRAME_LEN),
    .AW   (AW)
  ) u_ram (
    .clk    (CLK),
    .wr_en  (beat),
    .wr_bank(w_bank),
    .wr_addr(w_idx),
    .wr_data(tData[15:0]),
    .rd_en  (rd_go),
    .rd_bank(r_bank),
    .rd_addr(r_idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_ifft_frame_sequencer.sv
// Directed bench for ifft_frame_sequencer: config handshake, full and short
// frames, ping-pong backpressure, playback, underrun and mid-frame reset.
module tb_ifft_frame_sequencer;

  localparam int N = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] cfgData;
  logic        cfgValid;
  logic        cfgReady = 1'b0;
  logic [31:0] tData = '0;
  logic        tValid = 1'b0;
  logic        tLast = 1'b0;
  logic        tReady;
  logic        sampleTick = 1'b0;
  logic [15:0] val;
  logic        frameErr;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int fe_count = 0;
  int ur_count = 0;
  int cfg_count = 0;

  ifft_frame_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .cfgData   (cfgData),
    .cfgValid  (cfgValid),
    .cfgReady  (cfgReady),
    .tData     (tData),
    .tValid    (tValid),
    .tLast     (tLast),
    .tReady    (tReady),
    .sampleTick(sampleTick),
    .val       (val),
    .frameErr  (frameErr),
    .underrun  (underrun)
  );

  always #5 CLK = ~CLK;

  // Pulse counters sampled shortly after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (frameErr === 1'b1) fe_count++;
    if (underrun === 1'b1) ur_count++;
    if (cfgValid === 1'b1) cfg_count++;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive n beats whenever tReady is high; tLast goes on beat index last_at.
  task automatic send_beats(input int n, input int last_at, input logic [15:0] base);
    int sent = 0;
    int waited = 0;
    while (sent < n) begin
      @(negedge CLK);
      if (tReady === 1'b1) begin
        tValid = 1'b1;
        tData  = {16'hA5A5, 16'(base + sent)};
        tLast  = (sent == last_at);
        sent++;
      end else begin
        tValid = 1'b0;
        tLast  = 1'b0;
        waited++;
        if (waited > 500) begin
          checks++;
          errors++;
          $display("[TB] FAIL send_beats timeout: sent %0d required %0d", sent, n);
          break;
        end
      end
    end
    @(negedge CLK);
    tValid = 1'b0;
    tLast  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (cfgValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfgValid: got %b expected 0", cfgValid); end
    checks++; if (tReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_tReady: got %b expected 0", tReady); end
    checks++; if (val !== 16'h0000) begin errors++; $display("[TB] FAIL reset_val: got %h expected 0000", val); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_frameErr: got %b expected 0", frameErr); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (cfgData !== 16'h5554) begin errors++; $display("[TB] FAIL cfgData: got %h expected 5554", cfgData); end
  endtask

  task automatic test_config();
    cfgReady = 1'b1;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (cfgValid !== 1'b1) begin errors++; $display("[TB] FAIL config_valid: got %b expected 1", cfgValid); end
    checks++; if (tReady !== 1'b0) begin errors++; $display("[TB] FAIL config_tReady: got %b expected 0", tReady); end
    @(negedge CLK);
    checks++; if (cfgValid !== 1'b0) begin errors++; $display("[TB] FAIL config_drop: got %b expected 0", cfgValid); end
    checks++; if (tReady !== 1'b1) begin errors++; $display("[TB] FAIL receive_tReady: got %b expected 1", tReady); end
    @(negedge CLK);
    checks++; if (cfg_count != 1) begin errors++; $display("[TB] FAIL config_cycles: got %0d expected 1", cfg_count); end
  endtask

  task automatic test_full_frame();
    int fe0 = fe_count;
    int ur0 = ur_count;
    int bad = 0;
    send_beats(N, N - 1, 16'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge CLK); sampleTick = 1'b1;
      @(negedge CLK); sampleTick = 1'b0;
      checks++;
      if (val !== 16'(i)) begin errors++; $display("[TB] FAIL ramp_val[%0d]: got %h expected %h", i, val, 16'(i)); end
      @(negedge CLK);
      if (val !== 16'(i)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ramp_hold: got %0d changes expected 0", bad); end
    checks++; if (fe_count != fe0) begin errors++; $display("[TB] FAIL ramp_frameErr: got %0d pulses expected 0", fe_count - fe0); end
    checks++; if (ur_count != ur0) begin errors++; $display("[TB] FAIL ramp_underrun: got %0d pulses expected 0", ur_count - ur0); end
  endtask

  task automatic test_short_frame();
    int fe0 = fe_count;
    int c0 = cfg_count;
    send_beats(41, 40, 16'd100);
    repeat (4) @(negedge CLK);
    checks++; if (fe_count != fe0 + 1) begin errors++; $display("[TB] FAIL short_frameErr: got %0d pulses expected 1", fe_count - fe0); end
    checks++; if (cfg_count != c0 + 1) begin errors++; $display("[TB] FAIL short_next_config: got %0d expected 1", cfg_count - c0); end
    checks++; if (tReady !== 1'b1) begin errors++; $display("[TB] FAIL short_next_receive: got %b expected 1", tReady); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int stray = 0;
    send_beats(N, N - 1, 16'd200);
    cfgReady = 1'b0;
    tValid   = 1'b1;
    tLast    = 1'b0;
    tData    = 32'h0000BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (tReady !== 1'b0 || cfgValid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL both_full_stall: got %0d ready cycles expected 0", bad); end
    for (int i = 0; i < N; i++) begin
      @(negedge CLK); sampleTick = 1'b1;
      @(negedge CLK); sampleTick = 1'b0;
      if (tReady !== 1'b0) stray++;
      if (i <= 40) begin
        checks++;
        if (val !== 16'(100 + i)) begin errors++; $display("[TB] FAIL short_val[%0d]: got %h expected %h", i, val, 16'(100 + i)); end
      end
    end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL drain_stall: got %0d ready cycles expected 0", stray); end
    repeat (3) @(negedge CLK);
    checks++; if (cfgValid !== 1'b1) begin errors++; $display("[TB] FAIL reconfig_hold: got %b expected 1", cfgValid); end
    checks++; if (tReady !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_tReady: got %b expected 0", tReady); end
    tValid   = 1'b0;
    cfgReady = 1'b1;
    @(negedge CLK);
    checks++; if (tReady !== 1'b1) begin errors++; $display("[TB] FAIL reconfig_receive: got %b expected 1", tReady); end
    checks++; if (cfgValid !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_accept: got %b expected 0", cfgValid); end
  endtask

  task automatic test_playback();
    int ur0 = ur_count;
    for (int i = 0; i < N; i++) begin
      @(negedge CLK); sampleTick = 1'b1;
      @(negedge CLK); sampleTick = 1'b0;
      checks++;
      if (val !== 16'(200 + i)) begin errors++; $display("[TB] FAIL bankA_val[%0d]: got %h expected %h", i, val, 16'(200 + i)); end
    end
    @(negedge CLK);
    checks++; if (val !== 16'd263) begin errors++; $display("[TB] FAIL bankA_hold: got %h expected %h", val, 16'd263); end
    checks++; if (ur_count != ur0) begin errors++; $display("[TB] FAIL bankA_underrun: got %0d pulses expected 0", ur_count - ur0); end
  endtask

  task automatic test_underrun();
    int ur0 = ur_count;
    @(negedge CLK); sampleTick = 1'b1;
    @(negedge CLK); sampleTick = 1'b0;
    checks++; if (val !== 16'h0000) begin errors++; $display("[TB] FAIL underrun_val: got %h expected 0000", val); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL underrun_pulse: got %b expected 1", underrun); end
    @(negedge CLK);
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL underrun_width: got %b expected 0", underrun); end
    checks++; if (val !== 16'h0000) begin errors++; $display("[TB] FAIL underrun_hold: got %h expected 0000", val); end
    checks++; if (ur_count != ur0 + 1) begin errors++; $display("[TB] FAIL underrun_count: got %0d expected 1", ur_count - ur0); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    send_beats(20, -1, 16'd500);
    @(negedge CLK);
    checks++; if (tReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_frame_ready: got %b expected 1", tReady); end
    tValid = 1'b1;
    tData  = 32'h0000_0208;
    #2;
    RST = 1'b1;
    #1;
    checks++; if (tReady !== 1'b0) begin errors++; $display("[TB] FAIL async_tReady: got %b expected 0", tReady); end
    checks++; if (cfgValid !== 1'b0) begin errors++; $display("[TB] FAIL async_cfgValid: got %b expected 0", cfgValid); end
    checks++; if (val !== 16'h0000 || frameErr !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("[TB] FAIL async_outputs: got val=%h frameErr=%b underrun=%b expected 0", val, frameErr, underrun);
    end
    tValid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (cfgValid !== 1'b1) begin errors++; $display("[TB] FAIL fresh_config: got %b expected 1", cfgValid); end
    fe0 = fe_count;
    send_beats(N, N - 1, 16'd300);
    for (int i = 0; i < N; i++) begin
      @(negedge CLK); sampleTick = 1'b1;
      @(negedge CLK); sampleTick = 1'b0;
      checks++;
      if (val !== 16'(300 + i)) begin errors++; $display("[TB] FAIL restart_val[%0d]: got %h expected %h", i, val, 16'(300 + i)); end
    end
    checks++; if (fe_count != fe0) begin errors++; $display("[TB] FAIL restart_frameErr: got %0d pulses expected 0", fe_count - fe0); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_full_frame();
    test_short_frame();
    test_back_to_back();
    test_playback();
    test_underrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifft_frame_sequencer.md
IFFT_FRAME_SEQUENCER -- requirements
Module: ifft_frame_sequencer

Interface
REQ-001 The module SHALL have parameter FRAME_LEN, default 64, giving the IFFT frame length in samples; it SHALL be a power of two, 8..1024.
REQ-002 The module SHALL have parameter SCALE_SCH, default 14'h2AAA, giving the IFFT scaling schedule placed in cfgData[14:1].
REQ-003 The module SHALL have port CLK, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port cfgData, output, 16 bits: IFFT config word; bit0=0 (inverse), bits14:1=SCALE_SCH, bit15=0.
REQ-006 The module SHALL have port cfgValid, output, 1 bit: config word valid.
REQ-007 The module SHALL have port cfgReady, input, 1 bit: IFFT core accepts the config word.
REQ-008 The module SHALL have port tData, input, 32 bits: IFFT output sample; the real part is tData[15:0].
REQ-009 The module SHALL have ports tValid (input, 1 bit), tLast (input, 1 bit) and tReady (output, 1 bit): AXI-stream handshake for IFFT output.
REQ-010 The module SHALL have port sampleTick, input, 1 bit: single-cycle audio sample-rate strobe.
REQ-011 The module SHALL have port val, output, 16 bits: current audio sample to the DAC.
REQ-012 The module SHALL have port frameErr, output, 1 bit: one-cycle pulse on a tLast/length mismatch.
REQ-013 The module SHALL have port underrun, output, 1 bit: one-cycle pulse on sampleTick with no full bank.

Function
REQ-014 The module SHALL hold two banks (A, B) of FRAME_LEN x 16-bit samples, each flagged EMPTY or FULL.
REQ-015 The write FSM SHALL have states IDLE, CONFIG and RECEIVE.
REQ-016 IDLE->CONFIG SHALL occur when the write-target bank is EMPTY.
REQ-017 In CONFIG, cfgValid SHALL be 1, and the FSM SHALL move to RECEIVE on the cycle cfgValid&&cfgReady.
REQ-018 In RECEIVE, tReady SHALL be 1; each tValid&&tReady beat SHALL write tData[15:0] to bank[wIdx] and increment wIdx.
REQ-019 The frame SHALL end on the beat with wIdx==FRAME_LEN-1 or on a tLast beat, whichever comes first.
REQ-020 On frame end the module SHALL mark the bank FULL, toggle the write bank, clear wIdx and go to IDLE.
REQ-021 tLast with wIdx!=FRAME_LEN-1 SHALL pulse frameErr; unwritten entries keep stale data.
REQ-022 A beat at wIdx==FRAME_LEN-1 with tLast=0 SHALL pulse frameErr, and the following beats SHALL start the next frame.
REQ-023 tReady SHALL be 0 in IDLE and CONFIG; cfgValid, once raised, SHALL stay high until accepted.
REQ-024 On sampleTick with the read bank FULL, val SHALL be registered from bank[rIdx] one cycle after the tick, and rIdx SHALL increment.
REQ-025 After the tick that reads rIdx==FRAME_LEN-1, the module SHALL mark the read bank EMPTY, toggle the read bank and clear rIdx.
REQ-026 On sampleTick with the read bank EMPTY, val SHALL go to 16'h0000 and underrun SHALL pulse.
REQ-027 Between ticks, val SHALL hold its value.
REQ-028 When a write-side FULL-set and a read-side EMPTY-set occur in the same cycle on different banks, both SHALL take effect.
REQ-029 The same bank SHALL never be both write target and read source while FULL.
REQ-030 Read and write SHALL be independent, so playback of one bank overlaps capture of the other.

Reset
REQ-031 On RST, the module SHALL set the FSM to IDLE, both banks EMPTY, write and read bank to A, wIdx=rIdx=0, and val, cfgValid, tReady, frameErr and underrun to 0.
REQ-032 RST during CONFIG or RECEIVE SHALL abort the frame; bank contents need not be cleared.
REQ-033 The first CONFIG SHALL begin on the first clock after RST deasserts.

Structure
REQ-034 A shared package (ifft_pkg) SHALL hold FRAME_LEN default, the write-FSM state encoding, and cfgData bit-field positions/constants.
REQ-035 The module SHALL instantiate one sub-module, ifft_pingpong_ram: two banks with one write port (bank, addr, data, we) and one registered read port (bank, addr).

Verification
REQ-036 Reset release with cfgReady=1 -> cfgValid=1 for exactly one cycle, cfgData=16'h5554, then tReady=1.
REQ-037 Stream 64 beats ramp 0..63 with tLast on beat 63, then 64 sampleTicks -> val=0..63 in order, each one cycle after its tick, no frameErr or underrun.
REQ-038 tLast on beat 40 -> frameErr pulses once, bank marked FULL, next CONFIG issued.
REQ-039 Both banks FULL and tValid held high -> tReady=0 and no writes until the first read bank drains its 64th sample; then CONFIG re-issues.
REQ-040 sampleTick with no full bank -> val=0 and a one-cycle underrun pulse.
REQ-041 RST asserted mid-RECEIVE at beat 20 -> all outputs 0 asynchronously; after release a fresh CONFIG occurs and wIdx restarts at 0.
